// File: rtl/burst_locking_round_robin_arbiter_pkg.sv
// Shared definitions for the burst-locking round-robin arbiter: state encoding,
// width helpers and the CLOG2 convenience macro.
`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif

package burst_locking_round_robin_arbiter_pkg;

  localparam logic STATE_IDLE   = 1'b0;
  localparam logic STATE_LOCKED = 1'b1;

  typedef enum logic {
    ST_IDLE   = STATE_IDLE,
    ST_LOCKED = STATE_LOCKED
  } arb_state_e;

  // A zero limit means an unbounded burst, whose counter only needs one bit.
  function automatic int beat_width_f(input int max_beats);
    return (max_beats == 0) ? 1 : `CLOG2(max_beats + 1);
  endfunction

endpackage

// File: rtl/burst_locking_round_robin_arbiter_checker.sv
// Protocol checks for the arbiter: beats only while locked, grant one-hot,
// grant_valid consistent with grant.
module burst_locking_round_robin_arbiter_checker #(
  parameter int SIZE = 4
) (
  input logic            clock,
  input logic            resetn,
  input logic            locked,
  input logic            transfer,
  input logic [SIZE-1:0] grant,
  input logic            grant_valid
);

  transfer_only_when_locked: assert property (
    @(posedge clock) disable iff (!resetn) !(transfer && !locked)
  ) else $error("transfer asserted while arbiter idle");

  grant_onehot0: assert property (
    @(posedge clock) disable iff (!resetn) $onehot0(grant)
  ) else $error("grant not one-hot");

  grant_valid_matches: assert property (
    @(posedge clock) disable iff (!resetn) grant_valid == (|grant)
  ) else $error("grant_valid inconsistent with grant");

endmodule

// File: rtl/burst_locking_round_robin_arbiter_selector.sv
// Combinational round-robin picker: first set request at or above ptr, with
// wrap-around, built as rotate / fixed-priority / rotate-back.
module rotated_priority_selector #(
  parameter int SIZE  = 4,
  parameter int IDX_W = `CLOG2(SIZE)
) (
  input  logic [SIZE-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [SIZE-1:0]  gnt,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  function automatic logic [SIZE-1:0] barrel_rotator_left(input logic [SIZE-1:0] v,
                                                          input logic [IDX_W-1:0] s);
    logic [SIZE-1:0] r;
    r = '0;
    for (int i = 0; i < SIZE; i++) begin
      r[i] = v[(i + int'(s)) % SIZE];
    end
    return r;
  endfunction

  function automatic logic [SIZE-1:0] barrel_rotator_right(input logic [SIZE-1:0] v,
                                                           input logic [IDX_W-1:0] s);
    logic [SIZE-1:0] r;
    r = '0;
    for (int i = 0; i < SIZE; i++) begin
      r[(i + int'(s)) % SIZE] = v[i];
    end
    return r;
  endfunction

  function automatic logic [SIZE-1:0] static_priority_arbiter(input logic [SIZE-1:0] v);
    logic [SIZE-1:0] r;
    logic            found;
    r     = '0;
    found = 1'b0;
    for (int i = 0; i < SIZE; i++) begin
      r[i]  = v[i] & ~found;
      found = found | v[i];
    end
    return r;
  endfunction

  logic [SIZE-1:0] rotated_s;
  logic [SIZE-1:0] picked_s;

  // Position ptr is moved to bit 0 so index 0 of the fixed-priority stage is the favourite.
  always_comb begin
    rotated_s = barrel_rotator_left(req, ptr);
    picked_s  = static_priority_arbiter(rotated_s);
    gnt       = barrel_rotator_right(picked_s, ptr);
    valid     = |req;
    idx       = '0;
    for (int i = 0; i < SIZE; i++) begin
      idx = idx | (gnt[i] ? IDX_W'(i) : IDX_W'(0));
    end
  end

endmodule

// File: rtl/burst_locking_round_robin_arbiter.sv
// Burst-granular round-robin arbiter: a winner holds the grant until last,
// the beat limit, or abandonment; priority then rotates past the winner.
module burst_locking_round_robin_arbiter
  import burst_locking_round_robin_arbiter_pkg::*;
#(
  parameter int SIZE       = 4,
  parameter int MAX_BEATS  = 16,
  parameter int BEAT_WIDTH = beat_width_f(MAX_BEATS),
  parameter int IDX_W      = `CLOG2(SIZE)
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic [SIZE-1:0]       requests,
  input  logic                  transfer,
  input  logic                  last,
  output logic [SIZE-1:0]       grant,
  output logic                  grant_valid,
  output logic [IDX_W-1:0]      grant_index,
  output logic [BEAT_WIDTH-1:0] beat_count
);

  localparam bit                    LIMIT_EN  = (MAX_BEATS != 0);
  localparam logic [BEAT_WIDTH-1:0] BEAT_LAST = LIMIT_EN ? BEAT_WIDTH'(MAX_BEATS - 1)
                                                         : BEAT_WIDTH'(0);
  localparam logic [IDX_W-1:0]      IDX_TOP   = IDX_W'(SIZE - 1);

  arb_state_e            state_q, state_d;
  logic [SIZE-1:0]       grant_q, grant_d;
  logic                  grant_valid_q, grant_valid_d;
  logic [IDX_W-1:0]      grant_index_q, grant_index_d;
  logic [IDX_W-1:0]      pointer_q, pointer_d;
  logic [BEAT_WIDTH-1:0] beat_count_q, beat_count_d;

  logic                  locked_s;
  logic [IDX_W-1:0]      next_index_s;
  logic                  beat_limit_s;
  logic                  abandon_s;
  logic                  release_s;
  logic [SIZE-1:0]       abandon_mask_s;
  logic [SIZE-1:0]       sel_req_s;
  logic [IDX_W-1:0]      sel_ptr_s;
  logic [SIZE-1:0]       sel_gnt_s;
  logic [IDX_W-1:0]      sel_idx_s;
  logic                  sel_valid_s;

  // Release detection and selector input muxing.
  always_comb begin
    locked_s       = (state_q == ST_LOCKED);
    next_index_s   = (grant_index_q == IDX_TOP) ? IDX_W'(0) : grant_index_q + IDX_W'(1);
    beat_limit_s   = LIMIT_EN && transfer && (beat_count_q == BEAT_LAST);
    abandon_s      = locked_s && !requests[grant_index_q] && !transfer;
    release_s      = locked_s && ((transfer && last) || beat_limit_s || abandon_s);
    abandon_mask_s = '0;
    abandon_mask_s[grant_index_q] = abandon_s;
    sel_req_s      = requests & ~abandon_mask_s;
    sel_ptr_s      = locked_s ? next_index_s : pointer_q;
  end

  rotated_priority_selector #(
    .SIZE  (SIZE),
    .IDX_W (IDX_W)
  ) u_selector (
    .req   (sel_req_s),
    .ptr   (sel_ptr_s),
    .gnt   (sel_gnt_s),
    .idx   (sel_idx_s),
    .valid (sel_valid_s)
  );

  // Next-state, grant and beat-counter logic.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    grant_index_d = grant_index_q;
    pointer_d     = pointer_q;
    beat_count_d  = beat_count_q;
    case (state_q)
      ST_IDLE: begin
        if (sel_valid_s) begin
          state_d       = ST_LOCKED;
          grant_d       = sel_gnt_s;
          grant_index_d = sel_idx_s;
          beat_count_d  = '0;
        end else begin
          grant_d       = '0;
          grant_index_d = '0;
          beat_count_d  = '0;
        end
      end
      ST_LOCKED: begin
        if (release_s) begin
          pointer_d    = next_index_s;
          beat_count_d = '0;
          if (sel_valid_s) begin
            grant_d       = sel_gnt_s;
            grant_index_d = sel_idx_s;
          end else begin
            state_d       = ST_IDLE;
            grant_d       = '0;
            grant_index_d = '0;
          end
        end else if (transfer) begin
          if (LIMIT_EN && (beat_count_q == BEAT_LAST)) begin
            beat_count_d = beat_count_q;
          end else begin
            beat_count_d = beat_count_q + BEAT_WIDTH'(1);
          end
        end else begin
          beat_count_d = beat_count_q;
        end
      end
      default: begin
        state_d       = ST_IDLE;
        grant_d       = '0;
        grant_index_d = '0;
        pointer_d     = '0;
        beat_count_d  = '0;
      end
    endcase
    grant_valid_d = |grant_d;
  end

  // State and output registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      grant_index_q <= '0;
      pointer_q     <= '0;
      beat_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      grant_valid_q <= grant_valid_d;
      grant_index_q <= grant_index_d;
      pointer_q     <= pointer_d;
      beat_count_q  <= beat_count_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = grant_valid_q;
  assign grant_index = grant_index_q;
  assign beat_count  = beat_count_q;

  burst_locking_round_robin_arbiter_checker #(
    .SIZE (SIZE)
  ) u_checker (
    .clock       (clock),
    .resetn      (resetn),
    .locked      (locked_s),
    .transfer    (transfer),
    .grant       (grant_q),
    .grant_valid (grant_valid_q)
  );

endmodule

// File: tb/tb_burst_locking_round_robin_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic checked against
// a behavioural owner/pointer/beat model of the arbitration rules.
module tb_burst_locking_round_robin_arbiter;

  localparam int SIZE      = 4;
  localparam int MAX_BEATS = 4;

  logic       clock = 1'b0;
  logic       resetn;
  logic [3:0] requests;
  logic       transfer;
  logic       last;
  logic [3:0] grant;
  logic       grant_valid;
  logic [1:0] grant_index;
  logic [2:0] beat_count;

  int checks = 0;
  int errors = 0;

  int m_owner;
  int m_ptr;
  int m_beats;

  always #5 clock = ~clock;

  burst_locking_round_robin_arbiter #(
    .SIZE      (SIZE),
    .MAX_BEATS (MAX_BEATS)
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .requests    (requests),
    .transfer    (transfer),
    .last        (last),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_index (grant_index),
    .beat_count  (beat_count)
  );

  function automatic int pick(input logic [3:0] req, input int ptr);
    int i;
    for (int k = 0; k < SIZE; k++) begin
      i = (ptr + k) % SIZE;
      if (req[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_beats = 0;
  endtask

  // Applies the arbitration rules to the inputs present at the coming edge.
  task automatic model_clock();
    logic [3:0] mask;
    logic       ab;
    logic       rel;
    if (m_owner < 0) begin
      if (requests != 4'b0000) begin
        m_owner = pick(requests, m_ptr);
        m_beats = 0;
      end
    end else begin
      ab  = !requests[m_owner] && !transfer;
      rel = (transfer && last) || (transfer && m_beats == MAX_BEATS - 1) || ab;
      if (rel) begin
        m_ptr = (m_owner + 1) % SIZE;
        mask  = requests;
        if (ab) mask[m_owner] = 1'b0;
        m_owner = pick(mask, m_ptr);
        m_beats = 0;
      end else if (transfer && m_beats < MAX_BEATS - 1) begin
        m_beats = m_beats + 1;
      end
    end
  endtask

  task automatic step();
    model_clock();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    requests = 4'b0000;
    transfer = 1'b0;
    last     = 1'b0;
    resetn   = 1'b0;
    @(posedge clock);
    #1;
    resetn = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    requests = 4'b1111;
    transfer = 1'b0;
    last     = 1'b0;
    resetn   = 1'b0;
    @(posedge clock);
    #1;
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b expected %b", grant, 4'b0000); end
    checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", grant_valid); end
    checks++; if (grant_index !== 2'd0) begin errors++; $display("FAIL reset_index: got %0d expected 0", grant_index); end
    checks++; if (beat_count !== 3'd0) begin errors++; $display("FAIL reset_beats: got %0d expected 0", beat_count); end
    resetn = 1'b1;
    requests = 4'b0000;
    model_reset();
  endtask

  task automatic test_basic_burst();
    do_reset();
    requests = 4'b0110;
    step();
    checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL basic_first_grant: got %b expected %b", grant, 4'b0010); end
    checks++; if (grant_index !== 2'd1) begin errors++; $display("FAIL basic_first_index: got %0d expected 1", grant_index); end
    transfer = 1'b1;
    for (int b = 1; b <= 3; b++) begin
      step();
      checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL basic_hold_grant: beat %0d got %b expected %b", b, grant, 4'b0010); end
      checks++; if (beat_count !== 3'(b)) begin errors++; $display("FAIL basic_beat_count: got %0d expected %0d", beat_count, b); end
    end
    last = 1'b1;
    step();
    checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL basic_switch_grant: got %b expected %b", grant, 4'b0100); end
    checks++; if (grant_valid !== 1'b1) begin errors++; $display("FAIL basic_no_bubble: got %b expected 1", grant_valid); end
    checks++; if (beat_count !== 3'd0) begin errors++; $display("FAIL basic_beat_restart: got %0d expected 0", beat_count); end
    transfer = 1'b0;
    last     = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_seq [5];
    exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    requests = 4'b1111;
    step();
    checks++; if (grant !== exp_seq[0]) begin errors++; $display("FAIL rr_first: got %b expected %b", grant, exp_seq[0]); end
    for (int n = 1; n <= 4; n++) begin
      transfer = 1'b1;
      last     = 1'b0;
      step();
      checks++; if (beat_count !== 3'd1) begin errors++; $display("FAIL rr_mid_beat: burst %0d got %0d expected 1", n, beat_count); end
      last = 1'b1;
      step();
      checks++; if (grant !== exp_seq[n]) begin errors++; $display("FAIL rr_sequence: burst %0d got %b expected %b", n, grant, exp_seq[n]); end
      checks++; if (beat_count !== 3'd0) begin errors++; $display("FAIL rr_beat_reset: burst %0d got %0d expected 0", n, beat_count); end
    end
    transfer = 1'b0;
    last     = 1'b0;
  endtask

  task automatic test_forced_release();
    do_reset();
    requests = 4'b0010;
    step();
    requests = 4'b0101;
    step();
    checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL limit_setup: got %b expected %b", grant, 4'b0100); end
    transfer = 1'b1;
    for (int b = 1; b <= 3; b++) begin
      step();
      checks++; if (beat_count !== 3'(b)) begin errors++; $display("FAIL limit_count: got %0d expected %0d", beat_count, b); end
    end
    step();
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL limit_release: got %b expected %b", grant, 4'b0001); end
    checks++; if (dut.pointer_q !== 2'd3) begin errors++; $display("FAIL limit_pointer: got %0d expected 3", dut.pointer_q); end
    checks++; if (beat_count !== 3'd0) begin errors++; $display("FAIL limit_beat_restart: got %0d expected 0", beat_count); end
    last = 1'b1;
    step();
    checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL limit_regain: got %b expected %b", grant, 4'b0100); end
    transfer = 1'b0;
    last     = 1'b0;
  endtask

  task automatic test_abandon();
    do_reset();
    requests = 4'b0010;
    step();
    requests = 4'b0000;
    step();
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL abandon_grant: got %b expected %b", grant, 4'b0000); end
    checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL abandon_valid: got %b expected 0", grant_valid); end
    checks++; if (dut.state_q !== 1'b0) begin errors++; $display("FAIL abandon_state: got %b expected idle", dut.state_q); end
    checks++; if (dut.pointer_q !== 2'd2) begin errors++; $display("FAIL abandon_pointer: got %0d expected 2", dut.pointer_q); end
    requests = 4'b1010;
    step();
    checks++; if (grant !== 4'b1000) begin errors++; $display("FAIL abandon_next: got %b expected %b", grant, 4'b1000); end
    checks++; if (grant_index !== 2'd3) begin errors++; $display("FAIL abandon_next_index: got %0d expected 3", grant_index); end
  endtask

  task automatic test_sole_and_reset();
    do_reset();
    requests = 4'b1000;
    step();
    transfer = 1'b1;
    step();
    last = 1'b1;
    step();
    checks++; if (grant !== 4'b1000) begin errors++; $display("FAIL sole_regrant: got %b expected %b", grant, 4'b1000); end
    checks++; if (beat_count !== 3'd0) begin errors++; $display("FAIL sole_beat_restart: got %0d expected 0", beat_count); end
    last = 1'b0;
    step();
    checks++; if (beat_count !== 3'd1) begin errors++; $display("FAIL sole_second_burst: got %0d expected 1", beat_count); end
    transfer = 1'b0;
    resetn   = 1'b0;
    #1;
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL async_reset_grant: got %b expected %b", grant, 4'b0000); end
    checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL async_reset_valid: got %b expected 0", grant_valid); end
    model_reset();
    @(posedge clock);
    #1;
    resetn   = 1'b1;
    requests = 4'b1111;
    step();
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL post_reset_grant: got %b expected %b", grant, 4'b0001); end
  endtask

  task automatic test_random();
    logic [3:0] exp_grant;
    int         exp_index;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if (m_owner >= 0) begin
        requests = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 9) != 0) requests[m_owner] = 1'b1;
        transfer = 1'($urandom_range(0, 1));
        last     = transfer && ($urandom_range(0, 3) == 0);
      end else begin
        requests = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
        transfer = 1'b0;
        last     = 1'b0;
      end
      step();
      exp_grant = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
      exp_index = (m_owner < 0) ? 0 : m_owner;
      checks++; if (grant !== exp_grant) begin errors++; $display("FAIL rand_grant: cycle %0d got %b expected %b", c, grant, exp_grant); end
      checks++; if (grant_valid !== (m_owner >= 0)) begin errors++; $display("FAIL rand_valid: cycle %0d got %b expected %0d", c, grant_valid, m_owner >= 0); end
      checks++; if (grant_index !== 2'(exp_index)) begin errors++; $display("FAIL rand_index: cycle %0d got %0d expected %0d", c, grant_index, exp_index); end
      checks++; if (beat_count !== 3'(m_beats)) begin errors++; $display("FAIL rand_beats: cycle %0d got %0d expected %0d", c, beat_count, m_beats); end
    end
    transfer = 1'b0;
    last     = 1'b0;
    requests = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_basic_burst();
    test_round_robin();
    test_forced_release();
    test_abandon();
    test_sole_and_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
